regfile_mp_sb: RTL and testbench



---
 rtl/regfile_mp_sb.sv | 83 ++++++++
 tb/tb_regfile_mp_sb.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with same-cycle write bypass and a per-register
// pending-write scoreboard used by decode to stall on RAW hazards.
module regfile_mp_sb #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRP   = 2,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [AW-1:0]       wa,
   input  logic [XLEN-1:0]     wd,
   input  logic [NRP*AW-1:0]   ra,
   output logic [NRP*XLEN-1:0] rdata,
   output logic [NRP-1:0]      rbusy,
   input  logic                iss_valid,
   input  logic [AW-1:0]       iss_rd,
   output logic [NREGS-1:0]    busy_vec
);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (we && (wa != '0)) begin
         regs_d[wa] = wd;
      end
      for (int i = 1; i < NREGS; i++) begin
         if (we && (wa == AW'(i))) begin
            busy_d[i] = 1'b0;
         end
         // Applied after the clear so a newer producer keeps the register pending.
         if (iss_valid && (iss_rd == AW'(i))) begin
            busy_d[i] = 1'b1;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q <= '{default: '0};
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   assign busy_vec = busy_q;

   generate
      for (genvar gi = 0; gi < NRP; gi++) begin : g_rport
         logic [AW-1:0]   ra_k;
         logic [XLEN-1:0] rdata_k;
         logic            rbusy_k;

         assign ra_k = ra[gi*AW +: AW];

         always_comb begin
            rdata_k = regs_q[ra_k];
            rbusy_k = busy_q[ra_k];
            if (ra_k == '0) begin
               rdata_k = '0;
               rbusy_k = 1'b0;
            end else if (we && (wa == ra_k)) begin
               // A result landing this cycle resolves the hazard immediately.
               rdata_k = wd;
               rbusy_k = 1'b0;
            end
         end

         assign rdata[gi*XLEN +: XLEN] = rdata_k;
         assign rbusy[gi]              = rbusy_k;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: a vector table for the default build plus
// hand sequences for async reset and a 64-bit / 64-register / 3-port build.
module tb_regfile_mp_sb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic [4:0]  ra0, ra1;
   logic [63:0] rdata;
   logic [1:0]  rbusy;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic [31:0] busy_vec;

   regfile_mp_sb u_dut (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra({ra1, ra0}),
      .rdata(rdata), .rbusy(rbusy), .iss_valid(iss_valid), .iss_rd(iss_rd),
      .busy_vec(busy_vec)
   );

   logic         w_we;
   logic [5:0]   w_wa;
   logic [63:0]  w_wd;
   logic [17:0]  w_ra;
   logic [191:0] w_rdata;
   logic [2:0]   w_rbusy;
   logic         w_iss_valid;
   logic [5:0]   w_iss_rd;
   logic [63:0]  w_busy_vec;

   regfile_mp_sb #(.XLEN(64), .NREGS(64), .NRP(3)) u_dut64 (
      .clk(clk), .rst(rst), .we(w_we), .wa(w_wa), .wd(w_wd), .ra(w_ra),
      .rdata(w_rdata), .rbusy(w_rbusy), .iss_valid(w_iss_valid),
      .iss_rd(w_iss_rd), .busy_vec(w_busy_vec)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic        iv;
      logic [4:0]  ird;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [1:0]  eb;
      logic [31:0] ebv;
   } vec_t;

   vec_t tbl [16];

   task automatic idle_inputs();
      we = 1'b0; wa = '0; wd = '0; ra0 = '0; ra1 = '0; iss_valid = 1'b0; iss_rd = '0;
      w_we = 1'b0; w_wa = '0; w_wd = '0; w_ra = '0; w_iss_valid = 1'b0; w_iss_rd = '0;
   endtask

   initial begin
      // {we, wa, wd, ra0, ra1, iss_valid, iss_rd, exp rdata0, exp rdata1, exp rbusy, exp busy_vec}
      tbl[0]  = '{1'b1, 5'd3, 32'h12345678, 5'd3, 5'd3, 1'b0, 5'd0, 32'h12345678, 32'h12345678, 2'b00, 32'h0};
      tbl[1]  = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd0, 1'b0, 5'd0, 32'h12345678, 32'h0,        2'b00, 32'h0};
      tbl[2]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd0, 32'h0,        32'h0,        2'b00, 32'h0};
      tbl[3]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,        2'b00, 32'h0};
      tbl[4]  = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd0, 1'b1, 5'd9, 32'h0,        32'h0,        2'b00, 32'h0};
      tbl[5]  = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd3, 1'b0, 5'd0, 32'h0,        32'h12345678, 2'b01, 32'h200};
      tbl[6]  = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd9, 1'b0, 5'd0, 32'h0,        32'h0,        2'b11, 32'h200};
      tbl[7]  = '{1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd3, 1'b0, 5'd0, 32'hA5A5A5A5, 32'h12345678, 2'b00, 32'h200};
      tbl[8]  = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd0, 1'b0, 5'd0, 32'hA5A5A5A5, 32'h0,        2'b00, 32'h0};
      tbl[9]  = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 5'd4, 32'h0,        32'h0,        2'b00, 32'h0};
      tbl[10] = '{1'b1, 5'd4, 32'h1,        5'd4, 5'd0, 1'b1, 5'd4, 32'h1,        32'h0,        2'b00, 32'h10};
      tbl[11] = '{1'b0, 5'd0, 32'h0,        5'd4, 5'd4, 1'b0, 5'd0, 32'h1,        32'h1,        2'b11, 32'h10};
      tbl[12] = '{1'b1, 5'd4, 32'h2,        5'd5, 5'd4, 1'b0, 5'd0, 32'h0,        32'h2,        2'b00, 32'h10};
      tbl[13] = '{1'b0, 5'd0, 32'h0,        5'd4, 5'd0, 1'b0, 5'd0, 32'h2,        32'h0,        2'b00, 32'h0};
      tbl[14] = '{1'b1, 5'd5, 32'h7,        5'd5, 5'd0, 1'b0, 5'd0, 32'h7,        32'h0,        2'b00, 32'h0};
      tbl[15] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b0, 5'd0, 32'h7,        32'h0,        2'b00, 32'h0};

      idle_inputs();
      rst = 1'b1;
      #2;
      check("reset_busy_vec", 64'(busy_vec), 64'h0);
      check("reset_rbusy", 64'(rbusy), 64'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
         ra0 = tbl[i].ra0; ra1 = tbl[i].ra1;
         iss_valid = tbl[i].iv; iss_rd = tbl[i].ird;
         #2;
         $display("vec %0d: we=%0b wa=%0d ra0=%0d ra1=%0d rdata0=%h rdata1=%h rbusy=%b busy_vec=%h",
                  i, we, wa, ra0, ra1, rdata[31:0], rdata[63:32], rbusy, busy_vec);
         check($sformatf("vec%0d_rdata0", i), 64'(rdata[31:0]), 64'(tbl[i].e0));
         check($sformatf("vec%0d_rdata1", i), 64'(rdata[63:32]), 64'(tbl[i].e1));
         check($sformatf("vec%0d_rbusy", i), 64'(rbusy), 64'(tbl[i].eb));
         check($sformatf("vec%0d_busy_vec", i), 64'(busy_vec), 64'(tbl[i].ebv));
         @(negedge clk);
      end

      // Asynchronous reset mid-operation.
      idle_inputs();
      we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; iss_valid = 1'b1; iss_rd = 5'd7;
      @(negedge clk);
      idle_inputs();
      ra0 = 5'd5; ra1 = 5'd7;
      #2;
      $display("pre-reset: r5=%h busy_vec=%h rbusy=%b", rdata[31:0], busy_vec, rbusy);
      check("prerst_r5", 64'(rdata[31:0]), 64'hDEADBEEF);
      check("prerst_busy_vec", 64'(busy_vec), 64'h80);
      check("prerst_rbusy", 64'(rbusy), 64'b10);
      #1 rst = 1'b1;
      #1;
      $display("reset pulse: r5=%h busy_vec=%h rbusy=%b", rdata[31:0], busy_vec, rbusy);
      check("rst_r5", 64'(rdata[31:0]), 64'h0);
      check("rst_busy_vec", 64'(busy_vec), 64'h0);
      check("rst_rbusy", 64'(rbusy), 64'h0);
      we = 1'b1; wa = 5'd6; wd = 32'h55; ra1 = 5'd6; iss_valid = 1'b1; iss_rd = 5'd8;
      #1;
      check("rst_bypass", 64'(rdata[63:32]), 64'h55);
      @(negedge clk);
      idle_inputs();
      rst = 1'b0;
      ra0 = 5'd6; ra1 = 5'd5;
      #2;
      $display("post-reset: r6=%h r5=%h busy_vec=%h", rdata[31:0], rdata[63:32], busy_vec);
      check("postrst_r6", 64'(rdata[31:0]), 64'h0);
      check("postrst_r5", 64'(rdata[63:32]), 64'h0);
      check("postrst_busy_vec", 64'(busy_vec), 64'h0);
      iss_valid = 1'b1; iss_rd = 5'd8;
      @(negedge clk);
      idle_inputs();
      #2;
      check("postrst_issue", 64'(busy_vec), 64'h100);
      @(negedge clk);

      // Wide build: three ports read distinct registers simultaneously.
      w_we = 1'b1; w_wa = 6'd1;  w_wd = 64'h1111_2222_3333_4444;
      @(negedge clk);
      w_wa = 6'd63; w_wd = 64'hFEDC_BA98_7654_3210;
      @(negedge clk);
      w_wa = 6'd32; w_wd = 64'h0BAD_F00D_CAFE_0032;
      w_ra = {6'd32, 6'd63, 6'd1};
      #2;
      check("w64_bypass_p2", w_rdata[191:128], 64'h0BAD_F00D_CAFE_0032);
      @(negedge clk);
      w_we = 1'b0; w_wa = '0; w_wd = '0;
      w_ra = {6'd32, 6'd63, 6'd1};
      #2;
      $display("w64 read: p0=%h p1=%h p2=%h rbusy=%b", w_rdata[63:0], w_rdata[127:64],
               w_rdata[191:128], w_rbusy);
      check("w64_p0_r1", w_rdata[63:0], 64'h1111_2222_3333_4444);
      check("w64_p1_r63", w_rdata[127:64], 64'hFEDC_BA98_7654_3210);
      check("w64_p2_r32", w_rdata[191:128], 64'h0BAD_F00D_CAFE_0032);
      check("w64_rbusy", 64'(w_rbusy), 64'h0);
      w_iss_valid = 1'b1; w_iss_rd = 6'd63;
      @(negedge clk);
      w_iss_valid = 1'b0; w_iss_rd = '0;
      w_ra = {6'd1, 6'd32, 6'd63};
      #2;
      check("w64_busy_vec", w_busy_vec, 64'h8000_0000_0000_0000);
      check("w64_rbusy_p0", 64'(w_rbusy), 64'b001);
      check("w64_p2_r1", w_rdata[191:128], 64'h1111_2222_3333_4444);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
